// File: rtl/mem_stage.sv
// Memory-access stage with MEM/WB register and request/acknowledge data-memory port.
// Optional sub-word (byte/halfword) access support is enabled by defining MEM_STAGE_SUBWORD_EN.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [1:0]  M_control,
    input  logic [1:0]  WB_control_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data,
    input  logic [4:0]  write_reg_in,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    input  logic        mem_fault_clr,
    output logic        mem_fault,
    output logic        out_valid,
    output logic [1:0]  WB_control,
    output logic [31:0] read_data,
    output logic [31:0] alu_result,
    output logic [4:0]  write_reg
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nx;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nx;

    logic        r_req, r_we, r_fault, r_out_valid;
    logic [31:0] r_addr, r_wdata, r_read_data, r_alu;
    logic [3:0]  r_be;
    logic [1:0]  r_wb;
    logic [4:0]  r_wreg;

    logic        w_req_nx, w_we_nx, w_fault_nx, w_out_valid_nx;
    logic [31:0] w_addr_nx, w_wdata_nx, w_read_data_nx, w_alu_nx;
    logic [3:0]  w_be_nx;
    logic [1:0]  w_wb_nx;
    logic [4:0]  w_wreg_nx;

    // Instruction held while its access is outstanding
    logic [1:0]  r_pend_wb, w_pend_wb_nx;
    logic [4:0]  r_pend_wreg, w_pend_wreg_nx;
    logic [31:0] r_pend_alu, w_pend_alu_nx;
    logic        r_pend_load, w_pend_load_nx;
    logic [1:0]  r_pend_size, w_pend_size_nx;
    logic        r_pend_uns, w_pend_uns_nx;

    logic        w_mem_op, w_misaligned, w_fault_set, w_stall;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load_data;

    assign w_mem_op = (M_control != 2'b00);

`ifdef MEM_STAGE_SUBWORD_EN
    function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = lane[0];
            default: bad = (lane != 2'b00);
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] f_store_be(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = 4'b0011 << lane;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] f_store_data(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] f_load_data(input logic [1:0] size, input logic uns,
                                                input logic [1:0] lane, input logic [31:0] rd);
        logic [31:0] sh;
        logic [31:0] res;
        sh = rd >> {lane, 3'b000};
        case (size)
            2'b00:   res = uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   res = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: res = rd;
        endcase
        return res;
    endfunction

    assign w_misaligned = f_misaligned(mem_size, alu_result_in[1:0]);
    assign w_be         = f_store_be(mem_size, alu_result_in[1:0]);
    assign w_wdata      = f_store_data(mem_size, store_data);
    assign w_load_data  = f_load_data(r_pend_size, r_pend_uns, r_pend_alu[1:0], dmem_rdata);
`else
    logic w_unused;
    assign w_misaligned = (alu_result_in[1:0] != 2'b00);
    assign w_be         = 4'b1111;
    assign w_wdata      = store_data;
    assign w_load_data  = dmem_rdata;
    assign w_unused     = ^{mem_size, mem_unsigned, r_pend_size, r_pend_uns};
`endif

    // Next-state, next MEM/WB contents and memory-port control
    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_req_nx       = r_req;
        w_we_nx        = r_we;
        w_addr_nx      = r_addr;
        w_wdata_nx     = r_wdata;
        w_be_nx        = r_be;
        w_out_valid_nx = 1'b0;
        w_wb_nx        = 2'b00;
        w_read_data_nx = 32'd0;
        w_alu_nx       = 32'd0;
        w_wreg_nx      = 5'd0;
        w_pend_wb_nx   = r_pend_wb;
        w_pend_wreg_nx = r_pend_wreg;
        w_pend_alu_nx  = r_pend_alu;
        w_pend_load_nx = r_pend_load;
        w_pend_size_nx = r_pend_size;
        w_pend_uns_nx  = r_pend_uns;
        w_fault_set    = 1'b0;
        w_stall        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid && !w_mem_op) begin
                    w_out_valid_nx = 1'b1;
                    w_wb_nx        = WB_control_in;
                    w_alu_nx       = alu_result_in;
                    w_wreg_nx      = write_reg_in;
                end else if (in_valid && w_misaligned) begin
                    w_fault_set = 1'b1;
                end else if (in_valid) begin
                    w_stall        = 1'b1;
                    w_state_nx     = ST_WAIT;
                    w_cnt_nx       = 8'd0;
                    w_req_nx       = 1'b1;
                    w_we_nx        = M_control[1] && !M_control[0];
                    w_addr_nx      = {alu_result_in[31:2], 2'b00};
                    w_wdata_nx     = w_wdata;
                    w_be_nx        = w_be;
                    w_pend_wb_nx   = WB_control_in;
                    w_pend_wreg_nx = write_reg_in;
                    w_pend_alu_nx  = alu_result_in;
                    w_pend_load_nx = M_control[0];
                    w_pend_size_nx = mem_size;
                    w_pend_uns_nx  = mem_unsigned;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    w_out_valid_nx = 1'b1;
                    w_wb_nx        = r_pend_wb;
                    w_alu_nx       = r_pend_alu;
                    w_wreg_nx      = r_pend_wreg;
                    w_read_data_nx = r_pend_load ? w_load_data : 32'd0;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_fault_set = 1'b1;
                end else begin
                    w_stall  = 1'b1;
                    w_cnt_nx = r_cnt + 8'd1;
                end
                if (dmem_ack || (r_cnt == LP_CNT_LAST)) begin
                    w_state_nx = ST_IDLE;
                    w_req_nx   = 1'b0;
                    w_we_nx    = 1'b0;
                    w_addr_nx  = 32'd0;
                    w_wdata_nx = 32'd0;
                    w_be_nx    = 4'b0000;
                end else begin
                    w_state_nx = ST_WAIT;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
        if (w_fault_set) begin
            w_fault_nx = 1'b1;
        end else if (mem_fault_clr) begin
            w_fault_nx = 1'b0;
        end else begin
            w_fault_nx = r_fault;
        end
    end

    // FSM state register and timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Memory-port, fault flag and MEM/WB pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_be        <= 4'b0000;
            r_fault     <= 1'b0;
            r_out_valid <= 1'b0;
            r_wb        <= 2'b00;
            r_read_data <= 32'd0;
            r_alu       <= 32'd0;
            r_wreg      <= 5'd0;
            r_pend_wb   <= 2'b00;
            r_pend_wreg <= 5'd0;
            r_pend_alu  <= 32'd0;
            r_pend_load <= 1'b0;
            r_pend_size <= 2'b00;
            r_pend_uns  <= 1'b0;
        end else begin
            r_req       <= w_req_nx;
            r_we        <= w_we_nx;
            r_addr      <= w_addr_nx;
            r_wdata     <= w_wdata_nx;
            r_be        <= w_be_nx;
            r_fault     <= w_fault_nx;
            r_out_valid <= w_out_valid_nx;
            r_wb        <= w_wb_nx;
            r_read_data <= w_read_data_nx;
            r_alu       <= w_alu_nx;
            r_wreg      <= w_wreg_nx;
            r_pend_wb   <= w_pend_wb_nx;
            r_pend_wreg <= w_pend_wreg_nx;
            r_pend_alu  <= w_pend_alu_nx;
            r_pend_load <= w_pend_load_nx;
            r_pend_size <= w_pend_size_nx;
            r_pend_uns  <= w_pend_uns_nx;
        end
    end

    // Stall is forced low during reset so every output reads zero
    assign mem_stall  = w_stall && rst_n;
    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign dmem_be    = r_be;
    assign mem_fault  = r_fault;
    assign out_valid  = r_out_valid;
    assign WB_control = r_wb;
    assign read_data  = r_read_data;
    assign alu_result = r_alu;
    assign write_reg  = r_wreg;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage (TIMEOUT_CYCLES=4); sub-word cases need MEM_STAGE_SUBWORD_EN.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  M_control, WB_control_in, mem_size;
    logic [31:0] alu_result_in, store_data, dmem_rdata;
    logic [4:0]  write_reg_in;
    logic        mem_unsigned, dmem_ack, mem_fault_clr;
    logic        mem_stall, dmem_req, dmem_we, mem_fault, out_valid;
    logic [31:0] dmem_addr, dmem_wdata, read_data, alu_result;
    logic [3:0]  dmem_be;
    logic [1:0]  WB_control;
    logic [4:0]  write_reg;

    typedef struct packed {
        logic [1:0]  wb;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .M_control(M_control),
        .WB_control_in(WB_control_in), .alu_result_in(alu_result_in),
        .store_data(store_data), .write_reg_in(write_reg_in), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .mem_stall(mem_stall), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mem_fault_clr(mem_fault_clr), .mem_fault(mem_fault), .out_valid(out_valid),
        .WB_control(WB_control), .read_data(read_data), .alu_result(alu_result),
        .write_reg(write_reg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [1:0] m, input logic [1:0] wb, input logic [31:0] alu,
                          input logic [31:0] sd, input logic [4:0] wr,
                          input logic [1:0] sz, input logic uns);
        in_valid = 1'b1; M_control = m; WB_control_in = wb; alu_result_in = alu;
        store_data = sd; write_reg_in = wr; mem_size = sz; mem_unsigned = uns;
    endtask

    task automatic idle_in();
        in_valid = 1'b0; M_control = 2'b00; WB_control_in = 2'b00; alu_result_in = 32'd0;
        store_data = 32'd0; write_reg_in = 5'd0; mem_size = 2'b10; mem_unsigned = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called right after set_in; acks on WAIT cycle waits+1
    task automatic mem_access(input int waits, input logic [31:0] rd, input logic we,
                              input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wd);
        int stalls = 0;
        #1;
        chk("issue_stall", {31'd0, mem_stall}, 32'd1);
        if (mem_stall) stalls++;
        step();
        for (int i = 0; i < waits + 1; i++) begin
            chk("wait_req", {31'd0, dmem_req}, 32'd1);
            chk("wait_we", {31'd0, dmem_we}, {31'd0, we});
            chk("wait_addr", dmem_addr, addr);
            chk("wait_be", {28'd0, dmem_be}, {28'd0, be});
            chk("wait_wdata", dmem_wdata, wd);
            if (i < waits) begin
                chk("wait_stall", {31'd0, mem_stall}, 32'd1);
                if (mem_stall) stalls++;
                step();
            end
        end
        dmem_ack = 1'b1; dmem_rdata = rd;
        #1;
        chk("ack_stall", {31'd0, mem_stall}, 32'd0);
        chk("stall_cycles", stalls, waits + 1);
        step();
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        idle_in();
        chk("req_drop", {31'd0, dmem_req}, 32'd0);
    endtask

    // Monitor: every write-back is matched against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_wb: got alu=%h wr=%0d expected no write-back",
                             alu_result, write_reg);
                end else begin
                    mon_e = q.pop_front();
                    chk("wb_ctl", {30'd0, WB_control}, {30'd0, mon_e.wb});
                    chk("read_data", read_data, mon_e.rd);
                    chk("alu_result", alu_result, mon_e.alu);
                    chk("write_reg", {27'd0, write_reg}, {27'd0, mon_e.wr});
                end
            end else begin
                chk("bubble_wb", {30'd0, WB_control}, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0; mem_fault_clr = 1'b0;
        idle_in();
        #12;
        chk("reset_zero", {31'd0, |{mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
            mem_fault, out_valid, WB_control, read_data, alu_result, write_reg}}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // ALU pass-through
        set_in(2'b00, 2'b10, 32'h0000_1234, 32'd0, 5'd5, 2'b10, 1'b0);
        q.push_back('{wb: 2'b10, rd: 32'd0, alu: 32'h0000_1234, wr: 5'd5});
        #1;
        chk("alu_stall", {31'd0, mem_stall}, 32'd0);
        step();
        idle_in();
        chk("alu_valid", {31'd0, out_valid}, 32'd1);

        // Word load, ack on 4th WAIT cycle
        set_in(2'b01, 2'b11, 32'h0000_0100, 32'd0, 5'd7, 2'b10, 1'b0);
        q.push_back('{wb: 2'b11, rd: 32'hDEAD_BEEF, alu: 32'h0000_0100, wr: 5'd7});
        mem_access(3, 32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 4'hF, 32'd0);

        // Word store, minimum latency
        set_in(2'b10, 2'b00, 32'h0000_0104, 32'h1122_3344, 5'd0, 2'b10, 1'b0);
        q.push_back('{wb: 2'b00, rd: 32'd0, alu: 32'h0000_0104, wr: 5'd0});
        mem_access(0, 32'h5555_5555, 1'b1, 32'h0000_0104, 4'hF, 32'h1122_3344);

`ifdef MEM_STAGE_SUBWORD_EN
        set_in(2'b10, 2'b00, 32'h0000_0102, 32'h0000_00AB, 5'd0, 2'b00, 1'b0);
        q.push_back('{wb: 2'b00, rd: 32'd0, alu: 32'h0000_0102, wr: 5'd0});
        mem_access(1, 32'd0, 1'b1, 32'h0000_0100, 4'b0100, 32'hABAB_ABAB);
        set_in(2'b01, 2'b11, 32'h0000_0103, 32'd0, 5'd4, 2'b00, 1'b0);
        q.push_back('{wb: 2'b11, rd: 32'hFFFF_FF80, alu: 32'h0000_0103, wr: 5'd4});
        mem_access(0, 32'h80FF_FFFF, 1'b0, 32'h0000_0100, 4'hF, 32'd0);
`endif

        // Misaligned word load
        set_in(2'b01, 2'b11, 32'h0000_0101, 32'd0, 5'd8, 2'b10, 1'b0);
        #1;
        chk("misal_stall", {31'd0, mem_stall}, 32'd0);
        step();
        idle_in();
        chk("misal_req", {31'd0, dmem_req}, 32'd0);
        chk("misal_fault", {31'd0, mem_fault}, 32'd1);
        chk("misal_bubble", {29'd0, out_valid, WB_control}, 32'd0);
        step();
        mem_fault_clr = 1'b1;
        step();
        mem_fault_clr = 1'b0;
        chk("fault_clr", {31'd0, mem_fault}, 32'd0);

        // Set and clear in the same cycle: set wins
        set_in(2'b01, 2'b11, 32'h0000_0102, 32'd0, 5'd8, 2'b10, 1'b0);
        mem_fault_clr = 1'b1;
        step();
        idle_in();
        mem_fault_clr = 1'b0;
        chk("fault_set_wins", {31'd0, mem_fault}, 32'd1);
        mem_fault_clr = 1'b1;
        step();
        mem_fault_clr = 1'b0;

        // Timeout with no ack
        set_in(2'b01, 2'b11, 32'h0000_0200, 32'd0, 5'd9, 2'b10, 1'b0);
        #1;
        chk("to_issue_stall", {31'd0, mem_stall}, 32'd1);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("to_wait_stall", {31'd0, mem_stall}, 32'd1);
            chk("to_wait_req", {31'd0, dmem_req}, 32'd1);
            step();
        end
        chk("to_last_req", {31'd0, dmem_req}, 32'd1);
        chk("to_last_stall", {31'd0, mem_stall}, 32'd0);
        step();
        idle_in();
        chk("to_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("to_fault", {31'd0, mem_fault}, 32'd1);
        chk("to_bubble", {31'd0, out_valid}, 32'd0);
        mem_fault_clr = 1'b1;
        step();
        mem_fault_clr = 1'b0;

        // Ack on the timeout cycle wins
        set_in(2'b01, 2'b11, 32'h0000_0200, 32'd0, 5'd9, 2'b10, 1'b0);
        q.push_back('{wb: 2'b11, rd: 32'hCAFE_F00D, alu: 32'h0000_0200, wr: 5'd9});
        mem_access(3, 32'hCAFE_F00D, 1'b0, 32'h0000_0200, 4'hF, 32'd0);
        chk("ack_wins_nofault", {31'd0, mem_fault}, 32'd0);

        // Ack in IDLE is ignored
        dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
        step();
        step();
        dmem_ack = 1'b0;
        chk("idle_ack_req", {31'd0, dmem_req}, 32'd0);

        // Reset in the middle of WAIT
        set_in(2'b01, 2'b11, 32'h0000_0300, 32'd0, 5'd3, 2'b10, 1'b0);
        step();
        step();
        chk("pre_rst_req", {31'd0, dmem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midwait_rst_zero", {31'd0, |{mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
            dmem_be, mem_fault, out_valid, WB_control, read_data, alu_result, write_reg}}, 32'd0);
        idle_in();
        dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
        step();
        rst_n = 1'b1;
        step();
        step();
        dmem_ack = 1'b0;
        chk("post_rst_req", {31'd0, dmem_req}, 32'd0);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

        repeat (3) step();
        chk("queue_empty", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline. It sits between the EX/MEM register and the write-back stage and contains the MEM/WB pipeline register. It drives a request/acknowledge data-memory port, stalls upstream stages while an access is outstanding, and presents `WB_control`, `read_data`, `alu_result` and the destination register to write-back. Non-memory instructions pass through with one-cycle latency.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of WAIT cycles before an access is aborted; range 1–255.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: an EX/MEM instruction is present.
- `M_control` in 2: [0] mem_read, [1] mem_write.
- `WB_control_in` in 2: [0] mem_to_reg, [1] reg_write; passed through.
- `alu_result_in` in 32: memory address, or the ALU result for non-memory instructions.
- `store_data` in 32: rt value for stores.
- `write_reg_in` in 5: destination register.
- `mem_size` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `mem_unsigned` in 1: zero-extend sub-word loads.
- `mem_stall` out 1: hold the PC, IF/ID and EX/MEM registers.
- `dmem_req` out 1: access request.
- `dmem_we` out 1: write enable.
- `dmem_addr` out 32: word-aligned address (bits [1:0] = 0).
- `dmem_wdata` out 32: lane-shifted store data.
- `dmem_be` out 4: byte enables.
- `dmem_ack` in 1: access complete; `dmem_rdata` is valid in the same cycle.
- `dmem_rdata` in 32: read word.
- `mem_fault_clr` in 1: clears `mem_fault`.
- `mem_fault` out 1: sticky flag for a misalignment or timeout.
- `out_valid`, `WB_control`(2), `read_data`(32), `alu_result`(32), `write_reg`(5): MEM/WB register outputs.

## Operation
- States:
  - IDLE: no access outstanding.
  - WAIT: `dmem_req` is held high until `dmem_ack` or timeout.
- In IDLE, with `in_valid` and no mem op: load the MEM/WB register and set `out_valid`=1. `read_data` is 0.
- In IDLE, with `in_valid`, a mem op and an aligned address:
  - Register `dmem_req`/`dmem_we`/`dmem_addr`/`dmem_wdata`/`dmem_be`, then go to WAIT.
  - `mem_stall` is high combinationally in this cycle.
  - A bubble enters MEM/WB.
- In WAIT, `mem_stall` = !`dmem_ack`.
- In WAIT, on `dmem_ack`:
  - Load MEM/WB. For loads, `read_data` is the extracted/extended data; for stores it is 0.
  - Drop `dmem_req` and return to IDLE.
  - Upstream advances on the same edge.
- Timeout counter:
  - Clears on entry to WAIT and increments each WAIT cycle without ack.
  - When it reaches `TIMEOUT_CYCLES`: drop `dmem_req`, set `mem_fault`, insert a bubble, return to IDLE, and deassert `mem_stall` that cycle.
  - If ack arrives on the timeout cycle, ack wins.
- Misalignment:
  - Conditions: word access with addr[1:0]≠0, or halfword with addr[0]≠0.
  - No request is issued, `mem_fault` is set, a bubble is inserted, and there is no stall.
- Bubble: `out_valid`=0 and `WB_control`=00, so write-back never writes.
- `mem_read` and `mem_write` both set: treated as a read.
- `dmem_ack` in IDLE is ignored.
- `mem_fault` set and clear in the same cycle: set wins.

## Timing
- Reset (asynchronous): state IDLE, counter 0, every output 0, `mem_fault` 0.
  - A late `dmem_ack` after reset is ignored.
  - An access in flight is abandoned with no write-back.
- Non-memory instruction: presented in cycle N, output in N+1.
- Memory op presented in N: `dmem_req` is high from N+1, and the result is output one cycle after the ack cycle. Minimum latency is 2 cycles (ack in N+1).
- `dmem_req` is stable, with constant address, data and enables, throughout WAIT.
- Upstream holds all inputs constant while `mem_stall`=1.

## Configuration
- `MEM_STAGE_SUBWORD_EN` defined:
  - Byte and halfword accesses are supported.
  - Store `dmem_be` and `dmem_wdata`: byte → 0001<<addr[1:0], data replicated ×4; half → 0011<<addr[1:0], data replicated ×2.
  - Loads select the lane by addr[1:0], then sign- or zero-extend.
- Undefined:
  - `mem_size` and `mem_unsigned` are ignored, and every access is a word access.
  - `dmem_be`=1111, `dmem_wdata`=`store_data`, `read_data`=`dmem_rdata`.
  - Only addr[1:0]≠0 faults.

## Test plan
- ALU op, `alu_result_in`=0x1234, `WB_control_in`=10 → next cycle `out_valid`=1, `alu_result`=0x1234, `WB_control`=10, `mem_stall`=0.
- Word load at 0x100, ack after 3 WAIT cycles with rdata 0xDEADBEEF:
  - `mem_stall` is high for 4 cycles.
  - `dmem_addr`=0x100 and `dmem_be`=F throughout.
  - `read_data`=0xDEADBEEF the cycle after ack.
- Store at 0x102 with size byte, data 0xAB (SUBWORD_EN) → `dmem_be`=0100, `dmem_wdata`=0xABABABAB.
  - Then a signed byte load at 0x103 with rdata 0x80FFFFFF → `read_data`=0xFFFFFF80.
- Word load at 0x101 → no `dmem_req`, `mem_fault`=1, a bubble with `WB_control`=00.
  - `mem_fault_clr` → `mem_fault`=0.
- `TIMEOUT_CYCLES`=4, with no ack:
  - `dmem_req` drops after 4 WAIT cycles, `mem_fault`=1, `mem_stall` releases.
  - Repeat with ack exactly on the 4th cycle → normal completion and no fault.
- Assert `rst_n`=0 mid-WAIT → all outputs 0 immediately. An ack arriving after reset produces no write-back.
